// File: rtl/tree_pkg.sv
// Shared definitions for the pipelined decision-tree classifier stages.
// Heap layout: level l holds nodes 2^l-1 .. 2^(l+1)-2, addressed with l+1 index bits.
package tree_pkg;

   localparam int KEY_W = 16;

   function automatic int level_base(input int l);
      return (1 << l) - 1;
   endfunction

   function automatic int idx_w(input int l);
      return l + 1;
   endfunction

endpackage

// File: rtl/tree_node_ram.sv
// Per-level threshold store: one write port, one registered read port.
// A same-address write and read in one cycle returns the data being written.
module tree_node_ram
   import tree_pkg::*;
#(
   parameter int ADDR_W = 1,
   parameter int DATA_W = KEY_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   if (ADDR_W <= 10) begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_W-1:0] mem_r [DEPTH];

      // Write port plus write-first synchronous read
      always_ff @(posedge clk) begin
         if (we) begin
            mem_r[waddr] <= wdata;
         end
         rdata <= (we && (waddr == raddr)) ? wdata : mem_r[raddr];
      end
   end else begin : g_block
      (* ram_style = "block" *) logic [DATA_W-1:0] mem_r [DEPTH];

      // Write port plus write-first synchronous read
      always_ff @(posedge clk) begin
         if (we) begin
            mem_r[waddr] <= wdata;
         end
         rdata <= (we && (waddr == raddr)) ? wdata : mem_r[raddr];
      end
   end

endmodule

// File: rtl/tree_mid_level.sv
// Interior decision-tree stage: looks up the node threshold, compares it with the key
// and emits the child heap index two cycles later. Thresholds are loaded via cfg_*.
module tree_mid_level
   import tree_pkg::*;
#(
   parameter int level       = 1,
   parameter int total_level = 12,
   parameter int KEY_W       = tree_pkg::KEY_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [KEY_W-1:0]           Key_in,
   input  logic [idx_w(level)-1:0]    Index_in,
   input  logic                       valid_in,
   input  logic                       cfg_we,
   input  logic [level-1:0]           cfg_addr,
   input  logic [KEY_W-1:0]           cfg_data,
   output logic [KEY_W-1:0]           Key_out,
   output logic [level+1:0]           Index_out,
   output logic                       valid_out,
   output logic                       err_out
);

   localparam int IW = idx_w(level);
   localparam int OW = level + 2;
   localparam logic [IW-1:0] BASE = IW'(level_base(level));
   localparam logic [IW-1:0] TOP  = IW'(2 * level_base(level));
   localparam logic [OW-1:0] ONE  = OW'(1);
   localparam logic [OW-1:0] TWO  = OW'(2);

   if ((level < 1) || (level >= total_level)) begin : g_level_check
      $error("tree_mid_level: level must lie in 1 .. total_level-1");
   end

   logic [level-1:0] slot_s;
   logic             in_range_s;
   logic [KEY_W-1:0] thr_s;
   logic             lt_s;
   logic [OW-1:0]    child_s;

   logic [KEY_W-1:0] s1_key_r;
   logic [IW-1:0]    s1_idx_r;
   logic             s1_valid_r;
   logic             s1_err_r;

   // S1 slot decode and range check; the low bits of the subtraction give the slot
   always_comb begin
      slot_s     = Index_in[level-1:0] - BASE[level-1:0];
      in_range_s = (Index_in >= BASE) && (Index_in <= TOP);
   end

   tree_node_ram #(
      .ADDR_W (level),
      .DATA_W (KEY_W)
   ) u_node_ram (
      .clk   (clk),
      .we    (cfg_we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (slot_s),
      .rdata (thr_s)
   );

   // S1 pipeline registers, aligned with the RAM read
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_key_r   <= {KEY_W{1'b0}};
         s1_idx_r   <= {IW{1'b0}};
         s1_valid_r <= 1'b0;
         s1_err_r   <= 1'b0;
      end else begin
         s1_key_r   <= Key_in;
         s1_idx_r   <= Index_in;
         s1_valid_r <= valid_in;
         s1_err_r   <= valid_in && !in_range_s;
      end
   end

   // S2 unsigned compare and child index 2*i+1 (left) or 2*i+2 (right)
   always_comb begin
      lt_s    = s1_key_r < thr_s;
      child_s = {s1_idx_r, 1'b0} + (lt_s ? ONE : TWO);
   end

   // S2 output registers; index forced to zero for bubbles and out-of-range beats
   always_ff @(posedge clk) begin
      if (rst) begin
         Key_out   <= {KEY_W{1'b0}};
         Index_out <= {OW{1'b0}};
         valid_out <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         Key_out   <= s1_key_r;
         Index_out <= (s1_valid_r && !s1_err_r) ? child_s : {OW{1'b0}};
         valid_out <= s1_valid_r;
         err_out   <= s1_err_r;
      end
   end

endmodule

// File: tb/tb_tree_mid_level.sv
// Self-checking bench for tree_mid_level at levels 1 and 2, with a behavioural root
// stage in front of the level-1 instance for the chained-latency case.
module tb_tree_mid_level;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   // level-1 instance stimulus
   logic [15:0] k1;
   logic [1:0]  i1;
   logic        v1, we1;
   logic [0:0]  a1;
   logic [15:0] d1;
   logic [15:0] o1_key;
   logic [2:0]  o1_idx;
   logic        o1_v, o1_e;
   // level-2 instance stimulus
   logic [15:0] k2;
   logic [2:0]  i2;
   logic        v2, we2;
   logic [1:0]  a2;
   logic [15:0] d2;
   logic [15:0] o2_key;
   logic [3:0]  o2_idx;
   logic        o2_v, o2_e;
   // behavioural root stage (threshold 1000) feeding the level-1 instance
   logic        chain;
   logic [15:0] rk, root_key;
   logic        rv, root_valid;
   logic [1:0]  root_idx;
   logic [15:0] k1_s;
   logic [1:0]  i1_s;
   logic        v1_s;

   assign k1_s = chain ? root_key   : k1;
   assign i1_s = chain ? root_idx   : i1;
   assign v1_s = chain ? root_valid : v1;

   always @(posedge clk) begin
      if (rst) begin
         root_valid <= 1'b0;
         root_key   <= 16'd0;
         root_idx   <= 2'd0;
      end else begin
         root_valid <= rv;
         root_key   <= rk;
         root_idx   <= (rk < 16'd1000) ? 2'd1 : 2'd2;
      end
   end

   tree_mid_level #(.level(1), .total_level(12), .KEY_W(16)) dut1 (
      .clk(clk), .rst(rst), .Key_in(k1_s), .Index_in(i1_s), .valid_in(v1_s),
      .cfg_we(we1), .cfg_addr(a1), .cfg_data(d1),
      .Key_out(o1_key), .Index_out(o1_idx), .valid_out(o1_v), .err_out(o1_e));

   tree_mid_level #(.level(2), .total_level(12), .KEY_W(16)) dut2 (
      .clk(clk), .rst(rst), .Key_in(k2), .Index_in(i2), .valid_in(v2),
      .cfg_we(we2), .cfg_addr(a2), .cfg_data(d2),
      .Key_out(o2_key), .Index_out(o2_idx), .valid_out(o2_v), .err_out(o2_e));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: what each accepted beat must produce, from the heap rules
   typedef struct {
      bit z;    // outputs forced to reset values
      bit v;
      bit e;
      int key;
      int idx;
      bit r;    // reset was asserted when this beat was sampled
   } ent_t;

   int   thr [2][4];
   ent_t cur [2];
   ent_t prev [2];
   ent_t expc [2];
   int   nedges = 0;

   function automatic ent_t predict(input int d, input int lv, input bit r, input bit v,
                                    input int key, input int idx, input bit we,
                                    input int wa, input int wd);
      ent_t e;
      int base, slot, t;
      base  = (1 << lv) - 1;
      e.z   = 1'b0;
      e.v   = v;
      e.e   = 1'b0;
      e.key = key;
      e.idx = 0;
      e.r   = r;
      if (v) begin
         if (idx < base || idx > 2 * base) begin
            e.e = 1'b1;
         end else begin
            slot  = idx - base;
            t     = (we && wa == slot) ? wd : thr[d][slot];
            e.idx = (key < t) ? 2 * idx + 1 : 2 * idx + 2;
         end
      end
      return e;
   endfunction

   initial begin
      ent_t zero;
      zero = '{z: 1'b1, v: 1'b0, e: 1'b0, key: 0, idx: 0, r: 1'b0};
      for (int d = 0; d < 2; d++) begin
         prev[d] = zero;
         prev[d].r = 1'b1;
         for (int s = 0; s < 4; s++) thr[d][s] = 0;
      end
      forever begin
         @(posedge clk);
         cur[0] = predict(0, 1, rst, v1_s, 32'(k1_s), 32'(i1_s), we1, 32'(a1), 32'(d1));
         cur[1] = predict(1, 2, rst, v2,   32'(k2),   32'(i2),   we2, 32'(a2), 32'(d2));
         for (int d = 0; d < 2; d++) begin
            expc[d] = (cur[d].r || prev[d].r) ? zero : prev[d];
            prev[d] = cur[d];
         end
         if (we1) thr[0][a1] = 32'(d1);
         if (we2) thr[1][a2] = 32'(d2);
         nedges++;
      end
   end

   task automatic cmp(input string nm, input ent_t x, input logic v, input logic e,
                      input logic [15:0] k, input int idx);
      check({nm, ".valid_out"}, 32'(v), 32'(x.v));
      if (x.z || x.v) begin
         check({nm, ".err_out"},   32'(e), 32'(x.e));
         check({nm, ".Index_out"}, idx,    x.idx);
         check({nm, ".Key_out"},   32'(k), x.key);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (nedges > 0) begin
            cmp("L1", expc[0], o1_v, o1_e, o1_key, 32'(o1_idx));
            cmp("L2", expc[1], o2_v, o2_e, o2_key, 32'(o2_idx));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr1(input logic [0:0] a, input logic [15:0] d);
      we1 = 1'b1; a1 = a; d1 = d;
      tick();
      we1 = 1'b0;
   endtask

   task automatic wr2(input logic [1:0] a, input logic [15:0] d);
      we2 = 1'b1; a2 = a; d2 = d;
      tick();
      we2 = 1'b0;
   endtask

   task automatic beat1(input string nm, input logic [15:0] key, input logic [1:0] idx,
                        input int exp_idx);
      k1 = key; i1 = idx; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      check({nm, ".v"},   32'(o1_v),   1);
      check({nm, ".idx"}, 32'(o1_idx), exp_idx);
   endtask

   task automatic beat2(input string nm, input logic [15:0] key, input logic [2:0] idx,
                        input int exp_idx, input int exp_err);
      k2 = key; i2 = idx; v2 = 1'b1;
      tick();
      v2 = 1'b0;
      tick();
      check({nm, ".v"},   32'(o2_v),   1);
      check({nm, ".err"}, 32'(o2_e),   exp_err);
      check({nm, ".idx"}, 32'(o2_idx), exp_idx);
   endtask

   initial begin
      rst = 1'b1; chain = 1'b0; rk = 16'd0; rv = 1'b0;
      k1 = 16'd0; i1 = 2'd1; v1 = 1'b1; we1 = 1'b0; a1 = 1'b0; d1 = 16'd0;
      k2 = 16'd0; i2 = 3'd3; v2 = 1'b1; we2 = 1'b0; a2 = 2'd0; d2 = 16'd0;
      repeat (3) tick();

      // Release with a valid beat and a same-slot write to the level-1 RAM
      rst = 1'b0; v2 = 1'b0;
      k1 = 16'd50; i1 = 2'd1; v1 = 1'b1; we1 = 1'b1; a1 = 1'b0; d1 = 16'd100;
      tick();
      check("release.v1", 32'(o1_v), 0);
      check("release.v2", 32'(o2_v), 0);
      v1 = 1'b0; a1 = 1'b1; d1 = 16'd500;
      tick();
      we1 = 1'b0;
      check("first.v",   32'(o1_v),   1);
      check("first.idx", 32'(o1_idx), 3);

      wr2(2'd0, 16'd1000); wr2(2'd1, 16'd2000); wr2(2'd2, 16'd3000); wr2(2'd3, 16'd4000);

      beat1("k50_i1",   16'd50,    2'd1, 3);
      beat1("k100_i1",  16'd100,   2'd1, 4);
      beat1("k499_i2",  16'd499,   2'd2, 5);
      beat1("kffff_i2", 16'hFFFF,  2'd2, 6);

      // Back-to-back beats, then isolated bubbles
      for (int n = 0; n < 8; n++) begin
         k1 = 16'($urandom); i1 = (n % 2 == 1) ? 2'd2 : 2'd1; v1 = 1'b1;
         tick();
      end
      v1 = 1'b0; tick();
      v1 = 1'b1; tick();
      v1 = 1'b0; tick();
      v1 = 1'b1; tick();
      v1 = 1'b0; repeat (3) tick();

      // Write-first collision in S1, then a write landing while the beat is in S2
      k1 = 16'd50; i1 = 2'd1; v1 = 1'b1; we1 = 1'b1; a1 = 1'b0; d1 = 16'd10;
      tick();
      v1 = 1'b0; we1 = 1'b0;
      tick();
      check("collide.idx", 32'(o1_idx), 4);
      wr1(1'b0, 16'd100);
      k1 = 16'd50; i1 = 2'd1; v1 = 1'b1;
      tick();
      v1 = 1'b0; we1 = 1'b1; a1 = 1'b0; d1 = 16'd10;
      tick();
      we1 = 1'b0;
      check("s2write.idx", 32'(o1_idx), 3);
      wr1(1'b0, 16'd100);

      beat2("i2_low",  16'd5,    3'd2, 0, 1);
      beat2("i7_high", 16'd5,    3'd7, 0, 1);
      beat2("i3_ok",   16'd500,  3'd3, 7, 0);
      beat2("i6_eq",   16'd4000, 3'd6, 14, 0);

      // Chained with the root stage: three cycles from root input to level-1 output
      wr1(1'b0, 16'd300); wr1(1'b1, 16'd3000);
      chain = 1'b1;
      rk = 16'd200; rv = 1'b1; tick(); rv = 1'b0; tick(); tick();
      check("chain200.v",   32'(o1_v),   1);
      check("chain200.idx", 32'(o1_idx), 3);
      rk = 16'd2000; rv = 1'b1; tick(); rv = 1'b0; tick(); tick();
      check("chain2000.v",   32'(o1_v),   1);
      check("chain2000.idx", 32'(o1_idx), 5);
      chain = 1'b0;

      // Randomized traffic with concurrent config writes and one mid-run reset
      for (int n = 0; n < 1500; n++) begin
         rst = (n == 700 || n == 701);
         v1 = ($urandom_range(0, 3) != 0); k1 = 16'($urandom); i1 = 2'($urandom);
         we1 = ($urandom_range(0, 4) == 0); a1 = 1'($urandom); d1 = 16'($urandom);
         v2 = ($urandom_range(0, 3) != 0); k2 = 16'($urandom); i2 = 3'($urandom);
         we2 = ($urandom_range(0, 4) == 0); a2 = 2'($urandom); d2 = 16'($urandom);
         tick();
      end
      rst = 1'b0; v1 = 1'b0; v2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
